// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the 256-bit line-transfer interface.
// Serves one line read or line write at a time and answers with a one-cycle
// ack LATENCY edges after acceptance. Aborts and out-of-range addresses raise
// a sticky error flag; completed reads and writes are counted (saturating).
//
// state | meaning
// IDLE  | waiting for enable_i
// BUSY  | request captured, latency counter running down
// ACK   | ack_o high for this single cycle
module dmem_responder #(
  parameter int unsigned LATENCY  = 10,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned ADDR_LSB = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned HI_LSB = ADDR_LSB + IDX_W;
  localparam logic [7:0]  LAT    = 8'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;

  logic [LINE_W-1:0] memory [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              oor;
  logic              access;
  logic              mem_we;

  assign idx    = addr_q[HI_LSB-1:ADDR_LSB];
  assign oor    = |addr_q[31:HI_LSB];
  assign access = (state_q == BUSY) && enable_i && (cnt_q == 8'd1);
  assign mem_we = access && write_q && !oor;
  assign busy_o = (state_q != IDLE);

  // Line array write port; not reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) memory[idx] <= wdata_q;
  end

  // Request sequencing, registered responses, error flag and traffic counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      ack_o    <= 1'b0;
      data_o   <= '0;
      err_o    <= 1'b0;
      rd_cnt_o <= 16'd0;
      wr_cnt_o <= 16'd0;
    end else begin
      ack_o <= 1'b0;
      case (state_q)
        // The edge closing ACK may accept the next request (one transaction
        // per LATENCY+1 cycles); ACK itself never aborts or raises an error.
        IDLE, ACK: begin
          if (enable_i) begin
            addr_q  <= addr_i;
            wdata_q <= data_i;
            write_q <= write_i;
            cnt_q   <= LAT;
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (!enable_i) begin
            err_o   <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= IDLE;
          end else if (cnt_q > 8'd1) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            cnt_q   <= 8'd0;
            ack_o   <= 1'b1;
            state_q <= ACK;
            if (oor) err_o <= 1'b1;
            if (write_q) begin
              data_o <= wdata_q;
              if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
            end else begin
              data_o <= oor ? '0 : memory[idx];
              if (rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
